// File: rtl/bcd_rtc_counter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_rtc_counter_pkg
//   Shared definitions for the BCD time-of-day core and its display packer:
//   BCD field widths, the default prescaler divide, the 12h/24h hour reset
//   values, the {hour,min,sec} offsets inside time_bcd, and small BCD hour
//   helpers used by the hour counter.
// -----------------------------------------------------------------------------
package bcd_rtc_counter_pkg;

   // Field geometry
   localparam int DIGIT_W = 4;                 // one BCD digit
   localparam int FIELD_W = 2 * DIGIT_W;       // tens + ones
   localparam int TIME_W  = 3 * FIELD_W;       // {hour,min,sec}

   // Field offsets inside time_bcd (shared with the serial display packer)
   localparam int SEC_LSB  = 0;
   localparam int MIN_LSB  = SEC_LSB + FIELD_W;
   localparam int HOUR_LSB = MIN_LSB + FIELD_W;

   // Default clk cycles per second
   localparam int unsigned TICK_DIV_DEFAULT = 100_000_000;

   // Reset values
   localparam logic [FIELD_W-1:0] FIELD_RST    = 8'h00;
   localparam logic [FIELD_W-1:0] HOUR_RST_24H = 8'h00;
   localparam logic [FIELD_W-1:0] HOUR_RST_12H = 8'h12;

   // True when both digits are BCD and the hour is legal for the mode.
   // BCD values compare correctly as plain binary once both digits are <= 9.
   function automatic logic hour_valid(input logic [FIELD_W-1:0] h,
                                       input logic               mode24);
      logic ok;
      ok = (h[DIGIT_W-1:0] <= 4'd9) && (h[FIELD_W-1:DIGIT_W] <= 4'd9);
      if (mode24) begin
         ok = ok && (h <= 8'h23);
      end else begin
         ok = ok && (h != 8'h00) && (h <= 8'h12);
      end
      return ok;
   endfunction

   // Hour + 1 in BCD with the mode-dependent wrap (23->00 or 12->01).
   function automatic logic [FIELD_W-1:0] hour_inc(input logic [FIELD_W-1:0] h,
                                                   input logic               mode24);
      logic [FIELD_W-1:0] r;
      if (mode24 && (h == 8'h23)) begin
         r = 8'h00;
      end else if (!mode24 && (h == 8'h12)) begin
         r = 8'h01;
      end else if (h[DIGIT_W-1:0] == 4'd9) begin
         r = {h[FIELD_W-1:DIGIT_W] + 4'd1, 4'd0};
      end else begin
         r = {h[FIELD_W-1:DIGIT_W], h[DIGIT_W-1:0] + 4'd1};
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_rtc_counter_mod_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
//   Two-digit BCD modulo counter 00..{MAX_TENS,MAX_ONES}, used for the
//   seconds and minutes fields. Priority: clr > ld > inc. A load value with a
//   non-BCD digit or above the maximum loads 00 instead.
// Ports
//   clk  in   system clock
//   CR   in   asynchronous active-low reset (count -> 00)
//   clr  in   synchronous clear to 00
//   ld   in   synchronous load of d (validated)
//   d    in   BCD load value
//   inc  in   advance by one, wrapping max -> 00
//   q    out  registered BCD count
//   tc   out  carry: inc accepted while at max (wrap happening this edge)
// -----------------------------------------------------------------------------
module bcd_mod_counter
   import bcd_rtc_counter_pkg::*;
#(
   parameter int unsigned MAX_TENS = 5,
   parameter int unsigned MAX_ONES = 9
) (
   input  logic               clk,
   input  logic               CR,
   input  logic               clr,
   input  logic               ld,
   input  logic [FIELD_W-1:0] d,
   input  logic               inc,
   output logic [FIELD_W-1:0] q,
   output logic               tc
);

   localparam logic [DIGIT_W-1:0] TENS_MAX = DIGIT_W'(MAX_TENS);
   localparam logic [DIGIT_W-1:0] ONES_MAX = DIGIT_W'(MAX_ONES);

   logic [DIGIT_W-1:0] tens_q, ones_q;
   logic [DIGIT_W-1:0] tens_d, ones_d;
   logic               at_max;
   logic               d_ok;

   assign at_max = (tens_q == TENS_MAX) && (ones_q == ONES_MAX);

   // Ones digit must be BCD; below the top tens value any ones digit is fine,
   // at the top tens value the ones digit is bounded by ONES_MAX.
   assign d_ok = (d[DIGIT_W-1:0] <= 4'd9) &&
                 ((d[FIELD_W-1:DIGIT_W] < TENS_MAX) ||
                  ((d[FIELD_W-1:DIGIT_W] == TENS_MAX) && (d[DIGIT_W-1:0] <= ONES_MAX)));

   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      if (clr) begin
         {tens_d, ones_d} = FIELD_RST;
      end else if (ld) begin
         {tens_d, ones_d} = d_ok ? d : FIELD_RST;
      end else if (inc) begin
         if (at_max) begin
            {tens_d, ones_d} = FIELD_RST;
         end else if (ones_q == 4'd9) begin
            tens_d = tens_q + 4'd1;
            ones_d = 4'd0;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge CR) begin
      if (!CR) begin
         tens_q <= FIELD_RST[FIELD_W-1:DIGIT_W];
         ones_q <= FIELD_RST[DIGIT_W-1:0];
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign q  = {tens_q, ones_q};
   assign tc = inc && !clr && !ld && at_max;

endmodule

// File: rtl/bcd_rtc_counter.sv
// -----------------------------------------------------------------------------
// bcd_rtc_counter
//   BCD HH:MM:SS time-of-day core with 1 s prescaler, synchronous load,
//   per-field set pulses, 12/24-hour mode and alarm compare.
// Parameters
//   TICK_DIV  clk cycles per second (>= 2)
//   MODE_24H  1: hours 00..23; 0: hours 12,01..11 with pm flag
//   ALARM_EN  0: alarm logic removed, alarm tied 0
// Ports
//   clk         in   system clock
//   CR          in   asynchronous active-low reset
//   en          in   count enable (prescaler and time advance)
//   ld          in   load hour_in/min_in/sec_in (validated per field)
//   hour_in     in   BCD hour load value
//   min_in      in   BCD minute load value
//   sec_in      in   BCD second load value
//   inc_min     in   minute +1 (no hour carry), seconds cleared
//   inc_hour    in   hour +1 (12h: pm toggles on 11->12), seconds cleared
//   alarm_arm   in   enables alarm pulse
//   alarm_time  in   BCD {hour,min,sec} alarm value
//   time_bcd    out  BCD {hour,min,sec}
//   pm          out  PM flag (12h mode only)
//   sec_pulse   out  one cycle with each tick-driven seconds advance
//   day_wrap    out  one cycle on the end-of-day rollover
//   alarm       out  one cycle on the rising edge of time_bcd == alarm_time
// -----------------------------------------------------------------------------
module bcd_rtc_counter
   import bcd_rtc_counter_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
   parameter bit          MODE_24H = 1'b1,
   parameter bit          ALARM_EN = 1'b1
) (
   input  logic               clk,
   input  logic               CR,
   input  logic               en,
   input  logic               ld,
   input  logic [FIELD_W-1:0] hour_in,
   input  logic [FIELD_W-1:0] min_in,
   input  logic [FIELD_W-1:0] sec_in,
   input  logic               inc_min,
   input  logic               inc_hour,
   input  logic               alarm_arm,
   input  logic [TIME_W-1:0]  alarm_time,
   output logic [TIME_W-1:0]  time_bcd,
   output logic               pm,
   output logic               sec_pulse,
   output logic               day_wrap,
   output logic               alarm
);

   localparam int                 PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0]      PRESC_TC  = PW'(TICK_DIV - 1);
   localparam logic [FIELD_W-1:0] HOUR_RST  = MODE_24H ? HOUR_RST_24H : HOUR_RST_12H;

   // ---------------------------------------------------------------------
   // Control decode: ld beats the set pulses, which beat the tick
   // ---------------------------------------------------------------------
   logic [PW-1:0]      presc_q, presc_d;
   logic               tick;
   logic               set_any;
   logic               set_act;
   logic               tick_act;

   assign tick     = en && (presc_q == PRESC_TC);
   assign set_any  = inc_min || inc_hour;
   assign set_act  = !ld && set_any;
   assign tick_act = tick && !ld && !set_any;

   always_comb begin
      presc_d = presc_q;
      if (ld || set_any) begin
         presc_d = '0;
      end else if (tick) begin
         presc_d = '0;
      end else if (en) begin
         presc_d = presc_q + PW'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Seconds and minutes
   // ---------------------------------------------------------------------
   logic [FIELD_W-1:0] sec_q, min_q;
   logic               sec_tc, min_tc;
   logic               min_step;

   // Set pulses clear seconds; a minute set never carries into the hour
   // because the tick (the only carry source) is dropped that cycle.
   assign min_step = (set_act && inc_min) || sec_tc;

   bcd_mod_counter #(
      .MAX_TENS (5),
      .MAX_ONES (9)
   ) u_sec (
      .clk (clk),
      .CR  (CR),
      .clr (set_act),
      .ld  (ld),
      .d   (sec_in),
      .inc (tick_act),
      .q   (sec_q),
      .tc  (sec_tc)
   );

   bcd_mod_counter #(
      .MAX_TENS (5),
      .MAX_ONES (9)
   ) u_min (
      .clk (clk),
      .CR  (CR),
      .clr (1'b0),
      .ld  (ld),
      .d   (min_in),
      .inc (min_step),
      .q   (min_q),
      .tc  (min_tc)
   );

   // ---------------------------------------------------------------------
   // Hours, pm flag, pulses
   // ---------------------------------------------------------------------
   logic [FIELD_W-1:0] hour_q, hour_d;
   logic               pm_q, pm_d;
   logic               hour_carry;
   logic               hour_step;
   logic               sec_pulse_q, sec_pulse_d;
   logic               day_wrap_q, day_wrap_d;

   // min_tc is also raised by a minute set at 59; only a tick may carry.
   assign hour_carry = min_tc && tick_act;
   assign hour_step  = (set_act && inc_hour) || hour_carry;

   always_comb begin
      hour_d      = hour_q;
      pm_d        = pm_q;
      sec_pulse_d = tick_act;
      day_wrap_d  = 1'b0;
      if (ld) begin
         hour_d = hour_valid(hour_in, MODE_24H) ? hour_in : HOUR_RST;
      end else if (hour_step) begin
         hour_d = hour_inc(hour_q, MODE_24H);
         if (!MODE_24H && (hour_q == 8'h11)) begin
            pm_d = !pm_q;
         end
      end
      if (hour_carry) begin
         if (MODE_24H) begin
            day_wrap_d = (hour_q == 8'h23);
         end else begin
            day_wrap_d = (hour_q == 8'h11) && pm_q;
         end
      end
   end

   always_ff @(posedge clk or negedge CR) begin
      if (!CR) begin
         presc_q     <= '0;
         hour_q      <= HOUR_RST;
         pm_q        <= 1'b0;
         sec_pulse_q <= 1'b0;
         day_wrap_q  <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         hour_q      <= hour_d;
         pm_q        <= pm_d;
         sec_pulse_q <= sec_pulse_d;
         day_wrap_q  <= day_wrap_d;
      end
   end

   assign time_bcd[HOUR_LSB +: FIELD_W] = hour_q;
   assign time_bcd[MIN_LSB  +: FIELD_W] = min_q;
   assign time_bcd[SEC_LSB  +: FIELD_W] = sec_q;
   assign pm        = pm_q;
   assign sec_pulse = sec_pulse_q;
   assign day_wrap  = day_wrap_q;

   // ---------------------------------------------------------------------
   // Alarm: registered compare of the displayed time. match_q remembers the
   // previous compare so a held match (en=0) does not fire again; it tracks
   // the compare even while disarmed so arming during a match stays quiet.
   // ---------------------------------------------------------------------
   logic alarm_q;

   generate
      if (ALARM_EN) begin : g_alarm
         logic match_now;
         logic match_q;

         assign match_now = (time_bcd == alarm_time);

         always_ff @(posedge clk or negedge CR) begin
            if (!CR) begin
               match_q <= 1'b0;
               alarm_q <= 1'b0;
            end else begin
               match_q <= match_now;
               alarm_q <= alarm_arm && match_now && !match_q;
            end
         end
      end else begin : g_no_alarm
         assign alarm_q = 1'b0;
      end
   endgenerate

   assign alarm = alarm_q;

endmodule
